// File: rtl/led_pkg.sv
// led_pkg: shared types and helpers for the LED array controller.
// Channel modes, per-channel config bundle and the PWM compare.
package led_pkg;

   localparam int LED_MODE_W = 2;
   localparam int LED_DUTY_W = 16;

   typedef enum logic [LED_MODE_W-1:0] {
      LED_OFF     = 2'd0,
      LED_ON      = 2'd1,
      LED_BLINK   = 2'd2,
      LED_BREATHE = 2'd3
   } led_mode_e;

   // duty is held zero-extended; only the low PWM_W bits are ever non-zero
   typedef struct packed {
      led_mode_e             mode;
      logic [LED_DUTY_W-1:0] duty;
   } led_ch_cfg_t;

   function automatic logic led_pwm_on(
      input logic [LED_DUTY_W-1:0] d,
      input logic [LED_DUTY_W-1:0] cnt
   );
      return d > cnt;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: shared timebase prescaler and free-running PWM counter.
// tick_o is high for the one cycle the prescaler sits at TICK_DIV-1.
module led_tick_gen
   import led_pkg::*;
#(
   parameter int TICK_DIV = 1000,
   parameter int PWM_W    = 8
) (
   input  logic             clk,
   input  logic             resetn,
   output logic             tick_o,
   output logic [PWM_W-1:0] pwm_cnt_o
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] PRE_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0]    pre_q;
   logic [TW-1:0]    pre_d;
   logic [PWM_W-1:0] pwm_q;
   logic [PWM_W-1:0] pwm_d;

   assign tick_o    = (pre_q == PRE_LAST);
   assign pre_d     = tick_o ? '0 : pre_q + 1'b1;
   assign pwm_d     = pwm_q + 1'b1;
   assign pwm_cnt_o = pwm_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pre_q <= '0;
         pwm_q <= '0;
      end else begin
         pre_q <= pre_d;
         pwm_q <= pwm_d;
      end
   end

endmodule

// File: rtl/led_array_ctrl.sv
// led_array_ctrl: NUM_CH LED channels with OFF/ON/BLINK modes and PWM.
// Define LED_BREATHE_EN to add the triangular BREATHE mode (mode 3).
module led_array_ctrl
   import led_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int PWM_W       = 8,
   parameter int TICK_DIV    = 1000,
   parameter int BLINK_TICKS = 500,
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [PWM_W-1:0]  cfg_duty,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] led_o,
   output logic              tick_o
);

   localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int CW1 = CH_W + 1;
   localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [CW1-1:0] CH_LIM     = CW1'(NUM_CH);

   logic                  tick;
   logic [PWM_W-1:0]      pwm_cnt;
   logic [LED_DUTY_W-1:0] cnt_w;
   logic                  rdy_q;
   logic                  err_q;
   logic                  err_d;
   logic                  req;
   logic                  ch_ok;
   logic                  mode_ok;
   logic                  wr_ok;
   led_mode_e             wr_mode;

   led_tick_gen #(
      .TICK_DIV (TICK_DIV),
      .PWM_W    (PWM_W)
   ) u_tick (
      .clk       (clk),
      .resetn    (resetn),
      .tick_o    (tick),
      .pwm_cnt_o (pwm_cnt)
   );

   assign cnt_w   = LED_DUTY_W'(pwm_cnt);
   assign wr_mode = led_mode_e'(cfg_mode);
   assign req     = cfg_valid & rdy_q;
   assign ch_ok   = ({1'b0, cfg_ch} < CH_LIM);

`ifdef LED_BREATHE_EN
   assign mode_ok = 1'b1;
`else
   assign mode_ok = (wr_mode != LED_BREATHE);
`endif

   assign wr_ok = req & ch_ok & mode_ok;
   assign err_d = req & ~(ch_ok & mode_ok);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdy_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         err_q <= err_d;
      end
   end

   assign cfg_ready = rdy_q;
   assign cfg_err   = err_q;
   assign tick_o    = tick;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      led_ch_cfg_t   cfg_q;
      led_ch_cfg_t   cfg_d;
      logic [BW-1:0] bcnt_q;
      logic [BW-1:0] bcnt_d;
      logic          phase_q;
      logic          phase_d;
      logic          led_q;
      logic          led_d;
      logic          sel;
      logic          duty_on;
      logic          brth_on;

      assign sel     = wr_ok && (cfg_ch == CH_W'(i));
      assign duty_on = led_pwm_on(cfg_q.duty, cnt_w);

      // a write to this channel takes the place of the tick on that edge
      always_comb begin
         cfg_d   = cfg_q;
         bcnt_d  = bcnt_q;
         phase_d = phase_q;
         if (sel) begin
            cfg_d.mode = wr_mode;
            cfg_d.duty = LED_DUTY_W'(cfg_duty);
            if (wr_mode == LED_BLINK && cfg_q.mode != LED_BLINK) begin
               bcnt_d  = '0;
               phase_d = 1'b1;
            end
         end else if (tick) begin
            if (bcnt_q == BLINK_LAST) begin
               bcnt_d  = '0;
               phase_d = ~phase_q;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
      end

`ifdef LED_BREATHE_EN
      logic [PWM_W-1:0] lvl_q;
      logic [PWM_W-1:0] lvl_d;
      logic             dn_q;
      logic             dn_d;

      // endpoints hold one extra tick while the direction flips
      always_comb begin
         lvl_d = lvl_q;
         dn_d  = dn_q;
         if (sel) begin
            if (wr_mode == LED_BREATHE && cfg_q.mode != LED_BREATHE) begin
               lvl_d = '0;
               dn_d  = 1'b0;
            end
         end else if (tick) begin
            if (!dn_q) begin
               if (&lvl_q) dn_d = 1'b1;
               else        lvl_d = lvl_q + 1'b1;
            end else begin
               if (lvl_q == '0) dn_d = 1'b0;
               else             lvl_d = lvl_q - 1'b1;
            end
         end
      end

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            lvl_q <= '0;
            dn_q  <= 1'b0;
         end else begin
            lvl_q <= lvl_d;
            dn_q  <= dn_d;
         end
      end

      assign brth_on = led_pwm_on(LED_DUTY_W'(lvl_q), cnt_w);
`else
      assign brth_on = 1'b0;
`endif

      always_comb begin
         led_d = 1'b0;
         unique case (cfg_q.mode)
            LED_OFF:     led_d = 1'b0;
            LED_ON:      led_d = duty_on;
            LED_BLINK:   led_d = phase_q & duty_on;
            LED_BREATHE: led_d = brth_on;
         endcase
      end

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            cfg_q   <= '{mode: LED_OFF, duty: '0};
            bcnt_q  <= '0;
            phase_q <= 1'b1;
            led_q   <= 1'b0;
         end else begin
            cfg_q   <= cfg_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
         end
      end

      assign led_o[i] = led_q;
   end

endmodule
